// File: rtl/icache_pkg.sv
// Shared definitions for the instruction-cache refill sequencer.
package icache_pkg;

  // Sequencer states; encodings are fixed so debug dumps stay readable.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    DONE = 2'd2
  } refill_state_t;

  // Default geometry of a refill.
  localparam int DEF_WORDS_PER_LINE  = 4;
  localparam int DEF_WORD_WIDTH      = 32;
  localparam int DEF_ADDR_WIDTH      = 30;
  localparam int DEF_MAX_OUTSTANDING = 2;

  // Number of word-offset bits inside a default line.
  localparam int LINE_OFF_W = $clog2(DEF_WORDS_PER_LINE);

  // Offset width for an arbitrary power-of-two line size.
  function automatic int line_off_width(input int words);
    return $clog2(words);
  endfunction

endpackage

// File: rtl/refill_line_buffer.sv
// Write-indexed register array holding one cache line, read out flat.
module refill_line_buffer
  import icache_pkg::*;
#(
  parameter int WORDS = DEF_WORDS_PER_LINE,
  parameter int WIDTH = DEF_WORD_WIDTH,
  parameter int IDX_W = line_off_width(DEF_WORDS_PER_LINE)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic [IDX_W-1:0]       wr_idx,
  input  logic [WIDTH-1:0]       wr_data,
  output logic [WORDS*WIDTH-1:0] line_data
);

  genvar gi;
  generate
    for (gi = 0; gi < WORDS; gi++) begin : g_word
      logic [WIDTH-1:0] word_reg;

      // Each word captures write data only when the write index selects it.
      always_ff @(posedge clk) begin
        if (rst) begin
          word_reg <= '0;
        end else if (wr_en && (wr_idx == IDX_W'(gi))) begin
          word_reg <= wr_data;
        end
      end

      assign line_data[gi*WIDTH +: WIDTH] = word_reg;
    end
  endgenerate

endmodule

// File: rtl/icache_refill_sequencer.sv
// Backing-memory side of an I-cache line refill: critical-word-first
// request issue with a bounded number in flight, in-order response
// collection, early critical-word forward and line hand-off.
module icache_refill_sequencer
  import icache_pkg::*;
#(
  parameter int WORDS_PER_LINE  = DEF_WORDS_PER_LINE,
  parameter int WORD_WIDTH      = DEF_WORD_WIDTH,
  parameter int ADDR_WIDTH      = DEF_ADDR_WIDTH,
  parameter int MAX_OUTSTANDING = DEF_MAX_OUTSTANDING
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             i_halt,
  input  logic                             i_start,
  input  logic [ADDR_WIDTH-1:0]            i_miss_addr,
  output logic                             o_busy,
  output logic                             o_mem_req_valid,
  input  logic                             i_mem_req_ready,
  output logic [ADDR_WIDTH-1:0]            o_mem_req_addr,
  input  logic                             i_mem_resp_valid,
  input  logic [WORD_WIDTH-1:0]            i_mem_resp_data,
  output logic                             o_mem_resp_ready,
  output logic                             o_crit_valid,
  output logic [WORD_WIDTH-1:0]            o_crit_data,
  output logic                             o_line_valid,
  input  logic                             i_line_ready,
  output logic [ADDR_WIDTH-1:0]            o_line_addr,
  output logic [WORDS_PER_LINE*WORD_WIDTH-1:0] o_line_data
);

  localparam int OFF_W = line_off_width(WORDS_PER_LINE);
  localparam int CNT_W = OFF_W + 1;

  refill_state_t         state_reg;
  logic [ADDR_WIDTH-1:0] base_reg;
  logic [OFF_W-1:0]      off_reg;
  logic [CNT_W-1:0]      req_cnt_reg;
  logic [CNT_W-1:0]      resp_cnt_reg;
  logic                  crit_valid_reg;
  logic [WORD_WIDTH-1:0] crit_data_reg;

  logic [CNT_W-1:0] in_flight;
  logic [OFF_W-1:0] req_idx;
  logic [OFF_W-1:0] wr_idx;
  logic             req_valid;
  logic             resp_ready;
  logic             req_fire;
  logic             resp_fire;
  logic             is_fill;

  // Handshake terms derived from the registered state and counters.
  always_comb begin
    is_fill    = (state_reg == FILL);
    in_flight  = req_cnt_reg - resp_cnt_reg;
    req_idx    = off_reg + req_cnt_reg[OFF_W-1:0];
    wr_idx     = off_reg + resp_cnt_reg[OFF_W-1:0];
    // Halt deliberately does not gate the request so it stays stable until taken.
    req_valid  = is_fill
               && (req_cnt_reg < CNT_W'(WORDS_PER_LINE))
               && (in_flight < CNT_W'(MAX_OUTSTANDING));
    resp_ready = is_fill && (resp_cnt_reg < req_cnt_reg) && !i_halt;
    req_fire   = req_valid && i_mem_req_ready;
    resp_fire  = resp_ready && i_mem_resp_valid;
  end

  // Sequencer FSM, counters and critical-word capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      base_reg       <= '0;
      off_reg        <= '0;
      req_cnt_reg    <= '0;
      resp_cnt_reg   <= '0;
      crit_valid_reg <= 1'b0;
      crit_data_reg  <= '0;
    end else begin
      crit_valid_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (i_start && !i_halt) begin
            base_reg     <= {i_miss_addr[ADDR_WIDTH-1:OFF_W], {OFF_W{1'b0}}};
            off_reg      <= i_miss_addr[OFF_W-1:0];
            req_cnt_reg  <= '0;
            resp_cnt_reg <= '0;
            state_reg    <= FILL;
          end
        end
        FILL: begin
          if (req_fire) begin
            req_cnt_reg <= req_cnt_reg + 1'b1;
          end
          if (resp_fire) begin
            resp_cnt_reg <= resp_cnt_reg + 1'b1;
            if (resp_cnt_reg == '0) begin
              crit_valid_reg <= 1'b1;
              crit_data_reg  <= i_mem_resp_data;
            end
            if (resp_cnt_reg == CNT_W'(WORDS_PER_LINE - 1)) begin
              state_reg <= DONE;
            end
          end
        end
        DONE: begin
          if (i_line_ready && !i_halt) begin
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  refill_line_buffer #(
    .WORDS (WORDS_PER_LINE),
    .WIDTH (WORD_WIDTH),
    .IDX_W (OFF_W)
  ) u_line_buffer (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (resp_fire),
    .wr_idx    (wr_idx),
    .wr_data   (i_mem_resp_data),
    .line_data (o_line_data)
  );

  assign o_busy           = (state_reg != IDLE);
  assign o_mem_req_valid  = req_valid;
  assign o_mem_req_addr   = base_reg | {{(ADDR_WIDTH-OFF_W){1'b0}}, req_idx};
  assign o_mem_resp_ready = resp_ready;
  assign o_crit_valid     = crit_valid_reg;
  assign o_crit_data      = crit_data_reg;
  assign o_line_valid     = (state_reg == DONE);
  assign o_line_addr      = base_reg;

endmodule

// File: tb/tb_icache_refill_sequencer.sv
// Self-checking bench for icache_refill_sequencer: a behavioural model of the
// refill protocol, a simple in-order memory, and directed scenarios.
module tb_icache_refill_sequencer;

  localparam int W    = 4;
  localparam int DW   = 32;
  localparam int AW   = 30;
  localparam int MAXO = 2;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            i_halt = 1'b0;
  logic            i_start = 1'b0;
  logic [AW-1:0]   i_miss_addr = '0;
  logic            o_busy;
  logic            o_mem_req_valid;
  logic            i_mem_req_ready = 1'b1;
  logic [AW-1:0]   o_mem_req_addr;
  logic            i_mem_resp_valid = 1'b0;
  logic [DW-1:0]   i_mem_resp_data = '0;
  logic            o_mem_resp_ready;
  logic            o_crit_valid;
  logic [DW-1:0]   o_crit_data;
  logic            o_line_valid;
  logic            i_line_ready = 1'b0;
  logic [AW-1:0]   o_line_addr;
  logic [W*DW-1:0] o_line_data;

  icache_refill_sequencer #(
    .WORDS_PER_LINE (W), .WORD_WIDTH (DW), .ADDR_WIDTH (AW), .MAX_OUTSTANDING (MAXO)
  ) dut (
    .clk (clk), .rst (rst), .i_halt (i_halt), .i_start (i_start),
    .i_miss_addr (i_miss_addr), .o_busy (o_busy),
    .o_mem_req_valid (o_mem_req_valid), .i_mem_req_ready (i_mem_req_ready),
    .o_mem_req_addr (o_mem_req_addr), .i_mem_resp_valid (i_mem_resp_valid),
    .i_mem_resp_data (i_mem_resp_data), .o_mem_resp_ready (o_mem_resp_ready),
    .o_crit_valid (o_crit_valid), .o_crit_data (o_crit_data),
    .o_line_valid (o_line_valid), .i_line_ready (i_line_ready),
    .o_line_addr (o_line_addr), .o_line_data (o_line_data)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Memory contents: a per-test salt plus the low address byte.
  logic [DW-1:0] salt = 32'h0;
  function automatic logic [DW-1:0] fdat(input logic [AW-1:0] a);
    return salt + {24'h0, a[7:0]};
  endfunction

  // Behavioural model of the protocol.
  int            m_st = 0;        // 0 idle, 1 filling, 2 line ready
  logic [AW-1:0] m_base = '0;
  logic [AW-1:0] m_miss = '0;
  int            m_off = 0;
  int            m_nreq = 0;
  int            m_nresp = 0;
  bit            m_crit_pend = 0;
  bit            m_clean = 1;
  bit            e_req_fire = 0, e_resp_fire = 0, e_start = 0, e_hand = 0;
  bit            act_req_fire = 0, act_resp_fire = 0;
  logic [AW-1:0] act_req_addr = '0;

  // Observation logs used by the directed checks.
  int            cyc = 0;
  int            start_cyc = 0;
  logic [AW-1:0] req_log[$];
  int            req_cyc[$];
  int            crit_cnt = 0;
  logic [DW-1:0] crit_last = '0;
  int            resp_seen = 0;
  bit            resp_en = 1;

  function automatic logic [127:0] exp_line(input logic [AW-1:0] b);
    logic [127:0] l;
    l = '0;
    for (int i = 0; i < W; i++) l[i*DW +: DW] = fdat(b + AW'(i));
    return l;
  endfunction

  // Compare process: check every output against the model mid-cycle.
  always @(negedge clk) begin
    int            outst;
    bit            e_fill, e_req_valid, e_resp_ready;
    logic [AW-1:0] e_req_addr;
    outst        = m_nreq - m_nresp;
    e_fill       = (m_st == 1);
    e_req_valid  = e_fill && (m_nreq < W) && (outst < MAXO);
    e_resp_ready = e_fill && (outst > 0) && !i_halt;
    e_req_addr   = m_base + AW'((m_off + m_nreq) % W);
    chk("busy", o_busy, m_st != 0);
    chk("req_valid", o_mem_req_valid, e_req_valid);
    chk("resp_ready", o_mem_resp_ready, e_resp_ready);
    chk("line_valid", o_line_valid, m_st == 2);
    chk("crit_valid", o_crit_valid, m_crit_pend);
    if (e_req_valid) chk("req_addr", o_mem_req_addr, e_req_addr);
    if (m_crit_pend) chk("crit_data", o_crit_data, fdat(m_miss));
    if (m_st == 2) begin
      chk("line_addr", o_line_addr, m_base);
      chk("line_data", o_line_data, exp_line(m_base));
    end
    if (m_clean) begin
      chk("clean_line_data", o_line_data, 0);
      chk("clean_line_addr", o_line_addr, 0);
      chk("clean_crit_data", o_crit_data, 0);
      chk("clean_req_addr", o_mem_req_addr, 0);
    end
    e_req_fire    = e_req_valid && i_mem_req_ready;
    e_resp_fire   = e_resp_ready && i_mem_resp_valid;
    e_start       = (m_st == 0) && i_start && !i_halt;
    e_hand        = (m_st == 2) && i_line_ready && !i_halt;
    act_req_fire  = o_mem_req_valid && i_mem_req_ready;
    act_req_addr  = o_mem_req_addr;
    act_resp_fire = o_mem_resp_ready && i_mem_resp_valid;
    if (e_start) start_cyc = cyc;
    if (!rst && act_req_fire) begin
      req_log.push_back(o_mem_req_addr);
      req_cyc.push_back(cyc);
      $display("req  addr=%h cyc=%0d", o_mem_req_addr, cyc);
    end
    if (!rst && act_resp_fire) begin
      resp_seen++;
      $display("resp data=%h cyc=%0d", i_mem_resp_data, cyc);
    end
    if (o_crit_valid) begin
      crit_cnt++;
      crit_last = o_crit_data;
    end
    if (e_hand) $display("line addr=%h data=%h", o_line_addr, o_line_data);
  end

  // Model state update on the clock edge.
  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      m_st = 0; m_base = '0; m_off = 0; m_nreq = 0; m_nresp = 0;
      m_crit_pend = 0; m_clean = 1;
    end else begin
      m_crit_pend = e_resp_fire && (m_nresp == 0);
      case (m_st)
        0: if (e_start) begin
             m_st = 1; m_miss = i_miss_addr;
             m_base = {i_miss_addr[AW-1:2], 2'b00};
             m_off = int'(i_miss_addr[1:0]);
             m_nreq = 0; m_nresp = 0; m_clean = 0;
           end
        1: begin
             if (e_req_fire) m_nreq++;
             if (e_resp_fire) begin
               m_nresp++;
               if (m_nresp == W) m_st = 2;
             end
           end
        default: if (e_hand) m_st = 0;
      endcase
    end
  end

  // In-order memory: one cycle after acceptance it offers the response.
  logic [AW-1:0] mq[$];
  always @(posedge clk) begin
    if (rst) mq.delete();
    else begin
      if (act_resp_fire && mq.size() > 0) void'(mq.pop_front());
      if (act_req_fire) mq.push_back(act_req_addr);
    end
    #2;
    i_mem_resp_valid = resp_en && (mq.size() > 0);
    i_mem_resp_data  = (mq.size() > 0) ? fdat(mq[0]) : '0;
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic start(input logic [AW-1:0] a);
    req_log.delete(); req_cyc.delete(); crit_cnt = 0; resp_seen = 0;
    i_miss_addr = a; i_start = 1'b1;
    step();
    i_start = 1'b0;
  endtask

  task automatic wait_line();
    for (int k = 0; k < 60 && !o_line_valid; k++) step();
    chk("line_valid_timeout", o_line_valid, 1);
  endtask

  task automatic handoff();
    i_line_ready = 1'b1;
    step();
    i_line_ready = 1'b0;
    chk("busy_after_handoff", o_busy, 0);
  endtask

  task automatic chk_log(input string nm, input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                         input logic [AW-1:0] a2, input logic [AW-1:0] a3);
    chk({nm, "_count"}, req_log.size(), 4);
    if (req_log.size() == 4) begin
      chk({nm, "_a0"}, req_log[0], a0);
      chk({nm, "_a1"}, req_log[1], a1);
      chk({nm, "_a2"}, req_log[2], a2);
      chk({nm, "_a3"}, req_log[3], a3);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    step(2);
    // Reset values
    chk("rst_busy", o_busy, 0);
    chk("rst_req_valid", o_mem_req_valid, 0);
    chk("rst_line_valid", o_line_valid, 0);
    chk("rst_line_data", o_line_data, 0);
    rst = 1'b0;
    step();

    // Start while halted is ignored
    i_halt = 1'b1;
    start(30'h080);
    chk("halt_start_ignored", o_busy, 0);
    i_halt = 1'b0;

    // Aligned miss, zero-wait memory
    salt = 32'hA0 - 32'h00;
    start(30'h100);
    chk("t1_busy", o_busy, 1);
    chk("t1_req_valid", o_mem_req_valid, 1);
    wait_line();
    chk_log("t1", 30'h100, 30'h101, 30'h102, 30'h103);
    if (req_cyc.size() == 4) begin
      chk("t1_first_req_cyc", req_cyc[0], start_cyc + 1);
      for (int i = 1; i < 4; i++) chk("t1_consecutive", req_cyc[i] - req_cyc[i-1], 1);
    end
    chk("t1_crit_cnt", crit_cnt, 1);
    chk("t1_crit_data", crit_last, 32'hA0);
    chk("t1_line_addr", o_line_addr, 30'h100);
    chk("t1_line_data", o_line_data, 128'h000000A3_000000A2_000000A1_000000A0);
    handoff();

    // Wrap-around
    salt = 32'hB000_0000;
    start(30'h102);
    wait_line();
    chk_log("t2", 30'h102, 30'h103, 30'h100, 30'h101);
    chk("t2_crit_data", crit_last, 32'hB000_0002);
    chk("t2_line_data", o_line_data, 128'hB0000003_B0000002_B0000001_B0000000);
    handoff();

    // Outstanding limit with responses withheld
    salt = 32'hC000_0000;
    resp_en = 0;
    start(30'h204);
    step(6);
    chk("t3_accepted", req_log.size(), 2);
    chk("t3_req_valid_low", o_mem_req_valid, 0);
    resp_en = 1;
    wait_line();
    chk_log("t3", 30'h204, 30'h205, 30'h206, 30'h207);
    handoff();

    // Halt during fill, then halt against line hand-off
    salt = 32'hD000_0000;
    i_mem_req_ready = 1'b0;
    start(30'h301);
    step();
    i_halt = 1'b1;
    i_mem_req_ready = 1'b1;
    step(4);
    chk("t4_req_during_halt", req_log.size(), 2);
    chk("t4_resp_ready_halt", o_mem_resp_ready, 0);
    chk("t4_resp_frozen", resp_seen, 0);
    chk("t4_no_crit", crit_cnt, 0);
    i_halt = 1'b0;
    wait_line();
    chk_log("t4", 30'h301, 30'h302, 30'h303, 30'h300);
    i_halt = 1'b1;
    i_line_ready = 1'b1;
    step(3);
    chk("t4_done_held", o_line_valid, 1);
    chk("t4_busy_held", o_busy, 1);
    i_halt = 1'b0;
    step();
    i_line_ready = 1'b0;
    chk("t4_released", o_busy, 0);

    // Back-pressure on the request channel
    salt = 32'hE000_0000;
    i_mem_req_ready = 1'b0;
    start(30'h405);
    for (int k = 0; k < 3; k++) begin
      chk("t5_valid_held", o_mem_req_valid, 1);
      chk("t5_addr_held", o_mem_req_addr, 30'h405);
      step();
    end
    i_mem_req_ready = 1'b1;
    wait_line();
    chk_log("t5", 30'h405, 30'h406, 30'h407, 30'h404);
    handoff();

    // Reset mid-fill after two responses, then a fresh refill
    salt = 32'hF000_0000;
    start(30'h500);
    for (int k = 0; k < 40 && resp_seen < 2; k++) step();
    chk("t6_two_resp", resp_seen, 2);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t6_busy", o_busy, 0);
    chk("t6_req_valid", o_mem_req_valid, 0);
    chk("t6_req_addr", o_mem_req_addr, 0);
    chk("t6_resp_ready", o_mem_resp_ready, 0);
    chk("t6_crit_valid", o_crit_valid, 0);
    chk("t6_line_valid", o_line_valid, 0);
    chk("t6_line_addr", o_line_addr, 0);
    chk("t6_line_data", o_line_data, 0);
    step();
    salt = 32'h1234_0000;
    start(30'h50B);
    wait_line();
    chk_log("t6", 30'h50B, 30'h508, 30'h509, 30'h50A);
    chk("t6_crit_data", crit_last, 32'h1234_000B);
    chk("t6_line_data_lit", o_line_data, 128'h1234000B_1234000A_12340009_12340008);
    handoff();
    step(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/icache_refill_sequencer.md
# icache_refill_sequencer

Sequences the backing-memory side of an instruction-cache line refill. On a start pulse from the cache control unit it issues one word-read request per word of the missed line, critical word first with wrap-around, keeping at most MAX_OUTSTANDING requests in flight. It collects the in-order responses into a line buffer, forwards the critical word early, and presents the completed line to the array-update path with a valid/ready handshake.

## Interface
- WORDS_PER_LINE, 4: words per cache line; power of two, ≥2.
- WORD_WIDTH, 32: bits per word.
- ADDR_WIDTH, 30: word-address width.
- MAX_OUTSTANDING, 2: maximum accepted-but-unanswered memory requests; range 1..WORDS_PER_LINE.
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- i_halt  in  1  global stall; effects defined under Operation.
- i_start  in  1  refill request pulse from the control unit.
- i_miss_addr  in  ADDR_WIDTH  word address of the missed word; sampled with i_start.
- o_busy  out  1  high in every state except IDLE.
- o_mem_req_valid  out  1  word-read request valid.
- i_mem_req_ready  in  1  memory accepts the request.
- o_mem_req_addr  out  ADDR_WIDTH  requested word address.
- i_mem_resp_valid  in  1  read data valid; responses arrive in request order.
- i_mem_resp_data  in  WORD_WIDTH  read data.
- o_mem_resp_ready  out  1  sequencer accepts the response.
- o_crit_valid  out  1  one-cycle pulse carrying the critical word.
- o_crit_data  out  WORD_WIDTH  critical word.
- o_line_valid  out  1  full line available.
- i_line_ready  in  1  array-update path takes the line.
- o_line_addr  out  ADDR_WIDTH  line base address, low log2(WORDS_PER_LINE) bits zero.
- o_line_data  out  WORDS_PER_LINE*WORD_WIDTH  line data; word i is at bits [i*WORD_WIDTH +: WORD_WIDTH].

## Operation
- States: IDLE, FILL, DONE.
- Registers: base (line address), off (critical offset), req_cnt and resp_cnt (width log2(WORDS_PER_LINE)+1), and the line buffer.
- IDLE → FILL when i_start & ~i_halt. This latches base = i_miss_addr with the offset bits cleared, latches off = the low offset bits of i_miss_addr, and clears both counters. i_start in any other state, or while i_halt is high, is ignored.
- Request issue: o_mem_req_valid = FILL & (req_cnt < WORDS_PER_LINE) & (req_cnt − resp_cnt < MAX_OUTSTANDING).
- Request address: o_mem_req_addr = base | ((off + req_cnt) mod WORDS_PER_LINE).
- Request acceptance: req_cnt increments when o_mem_req_valid & i_mem_req_ready.
- Response acceptance: o_mem_resp_ready = FILL & (resp_cnt < req_cnt) & ~i_halt. On acceptance, data is written to line-buffer word (off + resp_cnt) mod WORDS_PER_LINE and resp_cnt increments.
- Critical word: when resp_cnt == 0 is accepted, o_crit_valid pulses for exactly one cycle on the next cycle, with o_crit_data holding that word.
- FILL → DONE on the cycle the last response is accepted (resp_cnt reaches WORDS_PER_LINE).
- DONE: o_line_valid is high; o_line_data and o_line_addr are stable. DONE → IDLE when i_line_ready & ~i_halt.
- i_halt: blocks start acceptance, response acceptance and line hand-off. It does NOT gate o_mem_req_valid, so a valid request stays stable until accepted, and an acceptance during halt is counted.
- rst: from any state, next cycle returns to IDLE and clears all outputs, counters and the line buffer to 0. Any in-flight memory transaction is abandoned; memory-side cleanup is the system's responsibility.

## Timing
- Reset values: every output is 0.
- i_start accepted at cycle T → o_busy=1 and the first o_mem_req_valid at T+1.
- A response accepted at cycle R → buffer updated at R+1. For the critical word, o_crit_valid is high at R+1 only.
- With zero-wait memory (ready always high, response one cycle after acceptance) and MAX_OUTSTANDING ≥ 2, requests issue on consecutive cycles starting at T+1.
- Last response at cycle L → o_line_valid at L+1. Hand-off at cycle H → o_busy=0 at H+1.
- A new i_start is accepted no earlier than H+1.
- A simultaneous request acceptance and response acceptance in one cycle is legal; both counters update.

## Structure
- Shared package icache_pkg holds:
  - the state encodings IDLE=0, FILL=1, DONE=2;
  - the default parameter values;
  - the line offset-width constant.
- Sub-module refill_line_buffer is the WORDS_PER_LINE-entry write-indexed register array with flat read-out. Its inputs are clk, rst, a write enable, a write index and write data.
- Counters, the FSM and handshake logic live in the top-level block.

## Test plan
- Aligned miss, zero-wait: i_miss_addr=0x100 → requests 0x100, 0x101, 0x102, 0x103 on consecutive cycles; data 0xA0..0xA3 → o_crit_data=0xA0; o_line_addr=0x100; o_line_data={0xA3,0xA2,0xA1,0xA0}.
- Wrap-around: i_miss_addr=0x102 → requests 0x102, 0x103, 0x100, 0x101; o_crit_data equals the first response; each word lands at its address index.
- Outstanding limit: MAX_OUTSTANDING=2, responses withheld → exactly 2 requests accepted, then o_mem_req_valid=0 until the first response is accepted.
- Halt: i_halt high mid-FILL with i_mem_resp_valid=1 → o_mem_resp_ready=0 and resp_cnt frozen; a pending request is still accepted. In DONE, i_line_ready=1 with halt → stays in DONE.
- Back-pressure: i_mem_req_ready low for 3 cycles → o_mem_req_valid and o_mem_req_addr are held constant throughout.
- Reset mid-FILL after 2 responses → next cycle all outputs are 0; a fresh i_start then completes a correct full line.
